// File: rtl/i2c_pkg.sv
// Shared constants for the I2C line conditioner: D0 status bit indices,
// P0/P1 control bit indices and the D0 reset value.
package i2c_pkg;

  // D0 status bit positions
  localparam int unsigned D0_SCL = 0;
  localparam int unsigned D0_SDA = 1;
  localparam int unsigned D0_STA = 2;
  localparam int unsigned D0_STO = 3;
  localparam int unsigned D0_ARB = 4;
  localparam int unsigned D0_STR = 5;
  localparam int unsigned D0_RDY = 6;
  localparam int unsigned D0_TMO = 7;

  // P0 drive bits (0 = pull the line low) and P1 flag-clear strobe bit
  localparam int unsigned P0_SCL = 0;
  localparam int unsigned P0_SDA = 1;
  localparam int unsigned P1_CLR = 7;

  // Both filtered lines idle high, every flag clear
  localparam logic [7:0] D0_RST = 8'h03;

endpackage

// File: rtl/i2c_line_conditioner_if.sv
// CPU/pad-side signal bundle of the I2C line conditioner.
//   p0_in  : CPU P0, [0] SCL drive value, [1] SDA drive value (0 = pull low)
//   p1_in  : CPU P1, [7] flag-clear strobe (rising edge)
//   scl_i  : raw SCL pad input      sda_i  : raw SDA pad input
//   scl_oe : 1 = pull SCL low       sda_oe : 1 = pull SDA low
//   d0_out : status byte to CPU D0  d1_out : last captured byte to CPU D1
// slave modport is the conditioner side, master the CPU/pad side.
interface i2c_line_conditioner_if;
  logic [7:0] p0_in;
  logic [7:0] p1_in;
  logic       scl_i;
  logic       sda_i;
  logic       scl_oe;
  logic       sda_oe;
  logic [7:0] d0_out;
  logic [7:0] d1_out;

  modport slave (
    input  p0_in, p1_in, scl_i, sda_i,
    output scl_oe, sda_oe, d0_out, d1_out
  );

  modport master (
    output p0_in, p1_in, scl_i, sda_i,
    input  scl_oe, sda_oe, d0_out, d1_out
  );
endinterface

// File: rtl/i2c_glitch_filter.sv
// Synchroniser plus stability filter for one asynchronous pad input.
// The filtered line follows the synchronised input only after it has differed
// for FILT_LEN consecutive clocks; rise_o/fall_o pulse for one clock in the
// cycle after the filtered line changes.
// Ports: clk, rst_n (async active-low), raw_i (pad), filt_o, rise_o, fall_o.
module i2c_glitch_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_s != filt_q) begin
      if (cnt_q == CntMax) begin
        filt_d = sync_s;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_line_conditioner.sv
// Pin-side stage between an 8-bit port CPU and open-drain I2C pads.
// Drives SCL/SDA pull-downs from P0, filters the pad inputs, detects START,
// STOP, arbitration loss and clock stretch, captures received bytes (D1) and
// reports status (D0). Flags are cleared by a rising edge on P1[7].
// Ports: clk, rst_n (async active-low), bus (i2c_line_conditioner_if.slave).
// Optional feature: define I2C_COND_TIMEOUT_EN to build the SCL-low timeout
// counter that sets D0[7]; otherwise D0[7] reads 0.
module i2c_line_conditioner
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  i2c_line_conditioner_if.slave   bus
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_scl_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (bus.scl_i),
    .filt_o (scl_f),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_sda_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (bus.sda_i),
    .filt_o (sda_f),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic       scl_oe_q, sda_oe_q;
  logic       p1_hist_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] d1_q, d1_d;
  logic [7:0] d0_q, d0_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       arb_q, arb_d;
  logic       rdy_q, rdy_d;
  logic       tmo_flag;
  logic       clr;
  logic       scl_steady_hi;
  logic       start_ev, stop_ev, arb_ev, byte_ev;
  logic       unused_bits;

  assign clr = bus.p1_in[P1_CLR] & ~p1_hist_q;

  // SDA edges only count as START/STOP when SCL neither moved nor is low
  assign scl_steady_hi = scl_f & ~scl_rise & ~scl_fall;
  assign start_ev      = sda_fall & scl_steady_hi;
  assign stop_ev       = sda_rise & scl_steady_hi;
  assign arb_ev        = scl_rise & bus.p0_in[P0_SDA] & ~sda_f;
  assign byte_ev       = scl_rise & (bit_cnt_q == 3'd7);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    d1_d      = d1_q;
    if (scl_rise) begin
      shift_d   = {shift_q[6:0], sda_f};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (start_ev || stop_ev) begin
      bit_cnt_d = '0;
    end
    if (byte_ev) begin
      d1_d = shift_d;
    end
  end

  // Set events take priority over the clear strobe
  assign start_d = start_ev | (start_q & ~clr);
  assign stop_d  = stop_ev  | (stop_q  & ~clr);
  assign arb_d   = arb_ev   | (arb_q   & ~clr);
  assign rdy_d   = byte_ev  | (rdy_q   & ~clr);

`ifdef I2C_COND_TIMEOUT_EN
  localparam logic [15:0] TmoLimit = 16'(TIMEOUT_CYC);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_q, tmo_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (scl_f) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TmoLimit) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
    tmo_d = ((tmo_cnt_d == TmoLimit) & ~scl_f) | (tmo_q & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign tmo_flag    = tmo_d;
  assign unused_bits = ^{bus.p0_in[7:2], bus.p1_in[6:0]};
`else
  assign tmo_flag    = 1'b0;
  assign unused_bits = ^{bus.p0_in[7:2], bus.p1_in[6:0], TIMEOUT_CYC[0]};
`endif

  // D0 reflects the flags as they are being registered this cycle
  always_comb begin
    d0_d         = '0;
    d0_d[D0_SCL] = scl_f;
    d0_d[D0_SDA] = sda_f;
    d0_d[D0_STA] = start_d;
    d0_d[D0_STO] = stop_d;
    d0_d[D0_ARB] = arb_d;
    d0_d[D0_STR] = bus.p0_in[P0_SCL] & ~scl_f;
    d0_d[D0_RDY] = rdy_d;
    d0_d[D0_TMO] = tmo_flag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      p1_hist_q <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      d1_q      <= '0;
      d0_q      <= D0_RST;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      arb_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      scl_oe_q  <= ~bus.p0_in[P0_SCL];
      sda_oe_q  <= ~bus.p0_in[P0_SDA];
      p1_hist_q <= bus.p1_in[P1_CLR];
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      d1_q      <= d1_d;
      d0_q      <= d0_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      arb_q     <= arb_d;
      rdy_q     <= rdy_d;
    end
  end

  assign bus.scl_oe = scl_oe_q;
  assign bus.sda_oe = sda_oe_q;
  assign bus.d0_out = d0_q;
  assign bus.d1_out = d1_q;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Directed self-checking bench for i2c_line_conditioner
// (SYNC_STAGES=2, FILT_LEN=4, TIMEOUT_CYC=16).
module tb_i2c_line_conditioner;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  i2c_line_conditioner_if bus ();

  i2c_line_conditioner #(
    .SYNC_STAGES (2),
    .FILT_LEN    (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Receiver-side bit: SCL low, set SDA (CPU drives the same value), SCL high
  task automatic send_bit(input logic b);
    bus.scl_i = 1'b0;
    step(8);
    bus.p0_in = {6'h3F, b, 1'b1};
    bus.sda_i = b;
    step(8);
    bus.scl_i = 1'b1;
    step(8);
  endtask

  task automatic clear_flags();
    bus.p1_in = 8'h00;
    step(1);
    bus.p1_in = 8'h80;
    step(2);
  endtask

  localparam logic [7:0] Byte5 = 8'h3C;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.p0_in = 8'hFF;
    bus.p1_in = 8'h80;
    bus.scl_i = 1'b0;
    bus.sda_i = 1'b0;

    // 1 Reset
    step(2);
    check8("rst_d0", bus.d0_out, 8'h03);
    check8("rst_oe", {6'h0, bus.scl_oe, bus.sda_oe}, 8'h00);
    check8("rst_d1", bus.d1_out, 8'h00);
    bus.scl_i = 1'b1;
    bus.sda_i = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(10);
    check8("idle_d0", bus.d0_out, 8'h03);
    bus.p0_in = 8'hFC;
    step(1);
    check8("drive_low", {6'h0, bus.scl_oe, bus.sda_oe}, 8'h03);
    bus.p0_in = 8'hFF;
    step(1);
    check8("drive_rel", {6'h0, bus.scl_oe, bus.sda_oe}, 8'h00);

    // 2 Glitch rejection, then a just-long-enough SDA pulse
    bus.sda_i = 1'b0;
    step(3);
    bus.sda_i = 1'b1;
    step(10);
    check8("glitch", bus.d0_out & 8'h7F, 8'h03);
    bus.sda_i = 1'b0;
    step(4);
    bus.sda_i = 1'b1;
    step(2);
    check8("sda_lat6", {7'h0, bus.d0_out[1]}, 8'h01);
    step(1);
    check8("sda_lat7", {7'h0, bus.d0_out[1]}, 8'h00);
    check8("start_pulse", {7'h0, bus.d0_out[2]}, 8'h01);
    step(10);
    check8("start_stop", bus.d0_out & 8'h7F, 8'h0F);
    clear_flags();
    check8("clr1", bus.d0_out & 8'h7F, 8'h03);

    // 3 Byte 8'hA5 framed by START/ACK/STOP
    bus.sda_i = 1'b0;
    step(8);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b0);
    bus.sda_i = 1'b1;
    bus.p0_in = 8'hFF;
    step(8);
    check8("byte_d1", bus.d1_out, 8'hA5);
    check8("byte_d0", bus.d0_out & 8'h7F, 8'h4F);
    clear_flags();
    check8("clr2", bus.d0_out & 8'h7F, 8'h03);

    // 4 Arbitration loss and clock stretch
    bus.scl_i = 1'b0;
    step(8);
    bus.sda_i = 1'b0;
    step(8);
    bus.scl_i = 1'b1;
    step(8);
    check8("arb", bus.d0_out & 8'h7F, 8'h11);
    bus.scl_i = 1'b0;
    step(8);
    check8("stretch", bus.d0_out & 8'h7F, 8'h30);
    bus.p0_in = 8'hFE;
    step(2);
    check8("no_stretch", bus.d0_out & 8'h7F, 8'h10);
    bus.p0_in = 8'hFF;
    bus.scl_i = 1'b1;
    step(8);
    bus.sda_i = 1'b1;
    step(8);
    clear_flags();
    check8("clr3", bus.d0_out & 8'h7F, 8'h03);

    // 5 Clear coinciding with the 8th SCL rise: byte_rdy wins, start_seen clears
    bus.p1_in = 8'h00;
    bus.sda_i = 1'b0;
    step(8);
    for (int i = 7; i >= 1; i--) send_bit(Byte5[i]);
    bus.scl_i = 1'b0;
    step(8);
    bus.p0_in = {6'h3F, Byte5[0], 1'b1};
    bus.sda_i = Byte5[0];
    step(8);
    bus.scl_i = 1'b1;
    step(6);
    bus.p1_in = 8'h80;
    step(1);
    check8("set_wins", bus.d0_out & 8'h7F, 8'h41);
    check8("byte2_d1", bus.d1_out, Byte5);
    bus.p0_in = 8'hFF;
    bus.sda_i = 1'b1;
    step(8);
    clear_flags();
    bus.scl_i = 1'b0;
    bus.sda_i = 1'b0;
    step(10);
    check8("simul_fall", bus.d0_out & 8'h7F, 8'h20);
    bus.scl_i = 1'b1;
    bus.sda_i = 1'b1;
    step(10);
    check8("simul_rise", bus.d0_out & 8'h7F, 8'h03);

    // 6 SCL held low for 20 clocks
    bus.scl_i = 1'b0;
    step(20);
    bus.scl_i = 1'b1;
    step(10);
`ifdef I2C_COND_TIMEOUT_EN
    check8("timeout", {7'h0, bus.d0_out[7]}, 8'h01);
`else
    check8("timeout", {7'h0, bus.d0_out[7]}, 8'h00);
`endif

    // Async reset releases the bus without waiting for a clock
    bus.p0_in = 8'hFC;
    step(2);
    check8("pre_rst_oe", {6'h0, bus.scl_oe, bus.sda_oe}, 8'h03);
    rst_n = 1'b0;
    #1;
    check8("async_rst_oe", {6'h0, bus.scl_oe, bus.sda_oe}, 8'h00);
    check8("async_rst_d0", bus.d0_out, 8'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
